// File: rtl/prog_loader.sv
// prog_loader: streams a program image into CPU memory, holds the CPU in
// reset while loading, releases it, counts clocks to halt and reports done.
// Optional watchdog: define LOADER_TIMEOUT_EN to stop runs at MAX_CYCLES.
module prog_loader #(
   parameter int unsigned AWIDTH     = 5,
   parameter int unsigned DWIDTH     = 8,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned MAX_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_last,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              cpu_rst,
   input  logic              cpu_halt,
   output logic              done,
   output logic              timeout,
   output logic [15:0]       cycle_count
);

   localparam int unsigned CW  = 16;
   localparam int unsigned RCW = 4;
   localparam logic [AWIDTH-1:0] LAST_ADDR = {AWIDTH{1'b1}};
   localparam logic [RCW-1:0]    RST_LIMIT = RCW'(RST_CYCLES);
   localparam logic [CW-1:0]     CNT_MAX   = {CW{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RESET,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state, state_d;
   logic [AWIDTH-1:0] ptr, ptr_d;
   logic [RCW-1:0]    rcnt, rcnt_d;
   logic              in_ready_d;
   logic              mem_we_d;
   logic [AWIDTH-1:0] mem_addr_d;
   logic [DWIDTH-1:0] mem_wdata_d;
   logic              cpu_rst_d;
   logic              done_d;
   logic [CW-1:0]     cycle_count_d;

`ifdef LOADER_TIMEOUT_EN
   localparam logic [CW-1:0] WDOG_LIMIT = CW'(MAX_CYCLES);
   logic timeout_q, timeout_d;
   assign timeout = timeout_q;
`else
   // Keeps the watchdog limit referenced when the watchdog is compiled out.
   logic unused_max_cycles;
   assign unused_max_cycles = (32'(MAX_CYCLES) == 32'd0);
   assign timeout = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         rcnt        <= '0;
         in_ready    <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         cpu_rst     <= 1'b1;
         done        <= 1'b0;
         cycle_count <= '0;
`ifdef LOADER_TIMEOUT_EN
         timeout_q   <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         ptr         <= ptr_d;
         rcnt        <= rcnt_d;
         in_ready    <= in_ready_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         cpu_rst     <= cpu_rst_d;
         done        <= done_d;
         cycle_count <= cycle_count_d;
`ifdef LOADER_TIMEOUT_EN
         timeout_q   <= timeout_d;
`endif
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state;
      ptr_d         = ptr;
      rcnt_d        = rcnt;
      in_ready_d    = in_ready;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr;
      mem_wdata_d   = mem_wdata;
      cpu_rst_d     = cpu_rst;
      done_d        = done;
      cycle_count_d = cycle_count;
`ifdef LOADER_TIMEOUT_EN
      timeout_d     = timeout_q;
`endif
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d       = S_LOAD;
               ptr_d         = '0;
               in_ready_d    = 1'b1;
               cpu_rst_d     = 1'b1;
               done_d        = 1'b0;
               cycle_count_d = '0;
`ifdef LOADER_TIMEOUT_EN
               timeout_d     = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            if (in_valid && in_ready) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ptr;
               mem_wdata_d = in_data;
               ptr_d       = ptr + 1'b1;
               // Last byte is either flagged or the top of memory; no wrap.
               if (in_last || (ptr == LAST_ADDR)) begin
                  in_ready_d = 1'b0;
                  rcnt_d     = '0;
                  state_d    = S_RESET;
               end
            end
         end
         S_RESET: begin
            if (rcnt == RST_LIMIT) begin
               state_d   = S_RUN;
               cpu_rst_d = 1'b0;
            end else begin
               rcnt_d = rcnt + 1'b1;
            end
         end
         S_RUN: begin
            if (cpu_halt) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
`ifdef LOADER_TIMEOUT_EN
               if (cycle_count == WDOG_LIMIT) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
                  cpu_rst_d = 1'b1;
               end else
`endif
               if (cycle_count != CNT_MAX) begin
                  cycle_count_d = cycle_count + 16'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes and run results are
// queued by the stimulus; a monitor pops and compares as the DUT presents them.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        in_last = 1'b0;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_rst;
   logic        cpu_halt;
   logic        done;
   logic        timeout;
   logic [15:0] cycle_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;
   typedef struct packed {
      logic [15:0] cc;
      logic        to;
   } dn_t;

   wr_t wq[$];
   dn_t dq[$];

   // Stand-in CPU: raises halt after halt_after run clocks out of reset.
   int run_cnt = 0;
   int halt_after = 1000000;
   assign cpu_halt = (run_cnt >= halt_after);
   always @(posedge clk) begin
      if (cpu_rst) run_cnt <= 0;
      else         run_cnt <= run_cnt + 1;
   end

   always #5 clk = ~clk;

   prog_loader #(
      .AWIDTH(5), .DWIDTH(8), .RST_CYCLES(2), .MAX_CYCLES(20)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .cpu_halt(cpu_halt),
      .done(done), .timeout(timeout), .cycle_count(cycle_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte at a negedge; returns at the negedge after it is accepted.
   task automatic send_byte(input logic [4:0] addr, input logic [7:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", int'(in_ready), 1);
      if (in_ready) wq.push_back('{addr: addr, data: d});
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("done_wait", int'(done), 1);
      @(negedge clk);
   endtask

   // Monitor: pop expected writes and run results when the DUT shows them.
   initial begin : monitor
      logic done_prev;
      wr_t  w;
      dn_t  e;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_we) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: got addr %0d data %h, none expected", mem_addr, mem_wdata);
            end else begin
               w = wq.pop_front();
               if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                  errors++;
                  $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                           mem_addr, mem_wdata, w.addr, w.data);
               end
            end
         end
         if (done && !done_prev) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: got cycle_count %0d, none expected", cycle_count);
            end else begin
               e = dq.pop_front();
               if (cycle_count !== e.cc || timeout !== e.to) begin
                  errors++;
                  $display("FAIL run_result: got cycle_count %0d timeout %0b expected %0d %0b",
                           cycle_count, timeout, e.cc, e.to);
               end
            end
         end
         done_prev = done;
      end
   end

   initial begin : stim
      int n;
      logic saw_ready;
      logic [7:0] b;

      // Reset and idle
      #12;
      chk("rst_cpu_rst", int'(cpu_rst), 1);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_cycle_count", int'(cycle_count), 0);
      chk("rst_timeout", int'(timeout), 0);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (10) @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 0);
      in_valid = 1'b0;

      // HLT image: one byte, 4 run clocks
      halt_after = 4;
      dq.push_back('{cc: 16'd4, to: 1'b0});
      pulse_start();
      send_byte(5'd0, 8'hF0, 1'b1);
      n = 0;
      while (cpu_rst && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("write_to_cpu_rst_release", n, 3);
      wait_done();
      chk("hlt_cpu_rst_in_done", int'(cpu_rst), 0);

      // JMP image with in_valid toggling
      halt_after = 12;
      dq.push_back('{cc: 16'd12, to: 1'b0});
      pulse_start();
      chk("load_asserts_cpu_rst", int'(cpu_rst), 1);
      send_byte(5'd0, 8'h42, 1'b0);
      @(negedge clk);
      send_byte(5'd1, 8'h42, 1'b0);
      @(negedge clk);
      send_byte(5'd2, 8'hF0, 1'b1);
      wait_done();

      // Full-depth image, no in_last
      halt_after = 3;
      dq.push_back('{cc: 16'd3, to: 1'b0});
      pulse_start();
      for (int i = 0; i < 32; i++) begin
         b = 8'(i) ^ 8'h5A;
         send_byte(5'(i), b, 1'b0);
      end
      chk("full_in_ready_drop", int'(in_ready), 0);
      saw_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      repeat (6) begin
         @(negedge clk);
         if (in_ready) saw_ready = 1'b1;
      end
      in_valid = 1'b0;
      chk("full_33rd_refused", int'(saw_ready), 0);
      wait_done();

      // Mid-run reset, then reload and run
      halt_after = 1000000;
      pulse_start();
      send_byte(5'd0, 8'h10, 1'b1);
      n = 0;
      while (cpu_rst && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_cpu_rst", int'(cpu_rst), 1);
      chk("midrst_cycle_count", int'(cycle_count), 0);
      chk("midrst_in_ready", int'(in_ready), 0);
      chk("midrst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      halt_after = 5;
      dq.push_back('{cc: 16'd5, to: 1'b0});
      pulse_start();
      send_byte(5'd0, 8'h21, 1'b0);
      send_byte(5'd1, 8'hF0, 1'b1);
      wait_done();

`ifdef LOADER_TIMEOUT_EN
      // Watchdog: image loops forever
      halt_after = 1000000;
      dq.push_back('{cc: 16'd20, to: 1'b1});
      pulse_start();
      send_byte(5'd0, 8'h40, 1'b1);
      wait_done();
      chk("wdog_timeout", int'(timeout), 1);
      chk("wdog_cpu_rst", int'(cpu_rst), 1);
`else
      chk("no_wdog_timeout", int'(timeout), 0);
`endif

      repeat (3) @(negedge clk);
      chk("write_queue_drained", wq.size(), 0);
      chk("done_queue_drained", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and run controller sitting directly upstream of the CPU top level. Accepts a program image as a byte stream over a valid/ready handshake and writes it sequentially into the CPU instruction/data memory. Holds the CPU in reset while loading, then releases it, measures clocks to `halt`, and reports completion. Replaces hierarchical memory pokes for system-level runs.

## Interface
- `AWIDTH`, 5: memory address width; memory depth is 2**AWIDTH.
- `DWIDTH`, 8: memory word and stream byte width.
- `RST_CYCLES`, 2: number of clocks `cpu_rst` stays asserted after loading; legal range 1..15.
- `MAX_CYCLES`, 1000: watchdog limit, used only with `LOADER_TIMEOUT_EN`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `in_valid` in 1: stream byte valid.
- `in_ready` out 1: loader can accept a byte.
- `in_data` in DWIDTH: stream byte.
- `in_last` in 1: marks the final byte of the image.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out AWIDTH: memory write address.
- `mem_wdata` out DWIDTH: memory write data.
- `cpu_rst` out 1: active-high reset, driven to the CPU `rst`.
- `cpu_halt` in 1: CPU `halt`.
- `done` out 1: run completed; held until the next `start`.
- `timeout` out 1: watchdog expired; held until the next `start`.
- `cycle_count` out 16: number of clocks the CPU ran before halting.

## Operation
- The FSM has five states: IDLE, LOAD, RESET, RUN and DONE.
- Reset values:
  - State is IDLE.
  - `in_ready`, `mem_we`, `done` and `timeout` are 0.
  - `mem_addr`, `mem_wdata` and `cycle_count` are 0.
  - `cpu_rst` is 1.
- IDLE/DONE → LOAD on `start`.
  - The write address pointer is cleared to 0.
  - `done`, `timeout` and `cycle_count` are cleared.
- LOAD:
  - `in_ready` is 1.
  - A byte is accepted on each edge where `in_valid & in_ready` is true.
  - On the following cycle the loader drives `mem_we`=1, `mem_addr`=pointer and `mem_wdata`=byte, then increments the pointer.
  - Throughput is one byte per clock.
- Load ends when the byte carrying `in_last` is accepted, or when the byte at address 2**AWIDTH-1 is accepted (implicit last, no wrap).
  - `in_ready` drops on the cycle after the final accept.
  - The final write still issues.
  - The FSM then moves to RESET.
- RESET:
  - `cpu_rst` stays 1 for RST_CYCLES clocks.
  - The FSM then moves to RUN with `cpu_rst` at 0.
- RUN:
  - `cycle_count` increments on every edge where `cpu_halt` is sampled 0, saturating at 16'hFFFF.
  - On the first edge where `cpu_halt` is sampled 1, the FSM moves to DONE, sets `done`=1 and freezes `cycle_count`.
- DONE:
  - `cpu_rst` is held 0 so the CPU stays halted and observable.
  - `start` restarts a load: LOAD asserts `cpu_rst`=1 immediately.
- Memory contents beyond the last written address are not touched.
- `start` in LOAD, RESET or RUN is ignored.
- `in_valid` outside LOAD is ignored and never accepted.
- If `rst` is asserted mid-operation, the block returns to IDLE asynchronously with all outputs at their reset values. A pending write in flight is dropped.

## Timing
- Accept-to-write latency is 1 clock.
- The last write to `cpu_rst` deassertion takes RST_CYCLES + 1 clocks.
- `done` rises on the clock after the edge that samples `cpu_halt`=1.
- `in_ready` is registered and has no combinational path from `in_valid`.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - In RUN, if `cycle_count` reaches MAX_CYCLES with `cpu_halt` still 0, the FSM moves to DONE with `timeout`=1 and `done`=1.
  - `cpu_rst` is then reasserted to stop the CPU.
- `LOADER_TIMEOUT_EN` undefined:
  - There is no watchdog; `timeout` is tied to 0.
  - RUN waits indefinitely, with `cycle_count` saturating.

## Test plan
- Reset and idle: with `rst` low, check `cpu_rst`=1, `in_ready`=0 and `done`=0. Raise `rst` and idle 10 clocks; no writes occur.
- HLT image: stream 1 byte {HLT, x} with `in_last`.
  - Exactly one write, to address 0.
  - `done`=1 with `cycle_count`=4.
- JMP image: stream {JMP,2}, {JMP,2}, {HLT,x} with `in_valid` toggling every other cycle.
  - Writes go to addresses 0, 1 and 2, one per accept.
  - `cycle_count`=12.
- Full-depth image: stream 32 bytes without `in_last`.
  - The 32nd byte goes to address 31, then `in_ready`=0.
  - A 33rd byte offered is never accepted.
- Mid-run reset and restart:
  - Assert `rst` during RUN; all outputs return to reset values immediately.
  - `start` after release reloads, and the run completes normally.
- Watchdog, with `LOADER_TIMEOUT_EN` and MAX_CYCLES=20: load an image whose entry is {JMP,0}.
  - `timeout`=1, `done`=1 and `cycle_count`=20.
  - `cpu_rst`=1 afterwards.
